uc_arbiter: RTL and testbench

Unit Clause Arbiter (uca). It collects unit-clause literals produced by `NUM_ENG` process engines (eng) and serialises them through a round-robin arbiter. Each selected literal is broadcast to every engine's Unit Clause Queue (ucq) in a single push. The broadcast is all-or-nothing: a literal is pushed only when no ucq is full, so all queues always hold identical contents.

---
 rtl/uc_arbiter_if.sv | 25 ++
 rtl/uc_arbiter.sv | 122 ++++++++++++
 tb/tb_uc_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uc_arbiter_if.sv
// Bundle between the unit clause arbiter, the process engines and their unit clause queues.
// The master side is the engines plus ucqs; the slave side is the arbiter.
interface uc_arbiter_if #(
  parameter int NUM_ENG   = 4,
  parameter int UC_LENGTH = 512
);
  localparam int LIT_W = $clog2(UC_LENGTH);

  logic [NUM_ENG-1:0]            eng2uca_valid;
  logic [NUM_ENG-1:0][LIT_W-1:0] eng2uca_lit;
  logic [NUM_ENG-1:0]            uca2eng_ready;
  logic [NUM_ENG-1:0]            ucq_full;
  logic                          uca2ucq_push;
  logic [LIT_W-1:0]              uca2ucq;

  modport master (
    output eng2uca_valid, eng2uca_lit, ucq_full,
    input  uca2eng_ready, uca2ucq_push, uca2ucq
  );

  modport slave (
    input  eng2uca_valid, eng2uca_lit, ucq_full,
    output uca2eng_ready, uca2ucq_push, uca2ucq
  );
endinterface

// File: rtl/uc_arbiter.sv
// Unit clause arbiter: round-robin collection of engine literals, broadcast all-or-nothing to every ucq.
// Optional feature: define UCA_DEDUP_EN to drop a literal equal to the previously accepted one.
module uc_arbiter #(
  parameter int NUM_ENG   = 4,
  parameter int UC_LENGTH = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  uc_arbiter_if.slave bus
);
  localparam int LIT_W = $clog2(UC_LENGTH);
  localparam int RR_W  = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  logic             hold_v_reg, hold_v_next;
  logic [LIT_W-1:0] hold_lit_reg, hold_lit_next;
  logic [RR_W-1:0]  rr_reg, rr_next;

  logic             can_push;
  logic             stage_free;
  logic             any_valid;
  logic             accept;
  logic             dup;
  logic             stage_new;
  logic [RR_W-1:0]  grant;
  logic [LIT_W-1:0] acc_lit;

  // A push requires every ucq to have room, so the queues never diverge.
  assign can_push   = hold_v_reg & ~|bus.ucq_full & ~flush & ~rst;
  assign stage_free = ~hold_v_reg | can_push;

  // Rotating priority search starting at rr, wrapping modulo NUM_ENG.
  always_comb begin
    int idx;
    grant     = rr_reg;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_ENG; k++) begin
      idx = int'(rr_reg) + k;
      if (idx >= NUM_ENG) idx = idx - NUM_ENG;
      if (!any_valid && bus.eng2uca_valid[idx]) begin
        any_valid = 1'b1;
        grant     = RR_W'(idx);
      end
    end
  end

  assign accept  = any_valid & stage_free & ~flush & ~rst;
  assign acc_lit = bus.eng2uca_lit[grant];

  generate
    for (genvar gi = 0; gi < NUM_ENG; gi++) begin : g_ready
      assign bus.uca2eng_ready[gi] = accept & (grant == RR_W'(gi));
    end
  endgenerate

`ifdef UCA_DEDUP_EN
  logic             last_v_reg, last_v_next;
  logic [LIT_W-1:0] last_lit_reg, last_lit_next;

  assign dup = last_v_reg & (acc_lit == last_lit_reg);

  always_comb begin
    last_v_next   = last_v_reg;
    last_lit_next = last_lit_reg;
    if (flush) begin
      last_v_next = 1'b0;
    end else if (accept) begin
      last_v_next   = 1'b1;
      last_lit_next = acc_lit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_v_reg   <= 1'b0;
      last_lit_reg <= '0;
    end else begin
      last_v_reg   <= last_v_next;
      last_lit_reg <= last_lit_next;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // A duplicate is consumed from the engine but never reaches the stage.
  assign stage_new = accept & ~dup;

  always_comb begin
    hold_v_next   = hold_v_reg;
    hold_lit_next = hold_lit_reg;
    rr_next       = rr_reg;
    if (flush) begin
      hold_v_next = 1'b0;
    end else begin
      if (can_push) hold_v_next = 1'b0;
      if (stage_new) begin
        hold_v_next   = 1'b1;
        hold_lit_next = acc_lit;
      end
      if (accept) begin
        rr_next = (grant == RR_W'(NUM_ENG - 1)) ? '0 : grant + RR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v_reg   <= 1'b0;
      hold_lit_reg <= '0;
      rr_reg       <= '0;
    end else begin
      hold_v_reg   <= hold_v_next;
      hold_lit_reg <= hold_lit_next;
      rr_reg       <= rr_next;
    end
  end

  assign bus.uca2ucq_push = can_push;
  assign bus.uca2ucq      = hold_lit_reg;
endmodule

// File: tb/tb_uc_arbiter.sv
// Bench for uc_arbiter: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a behavioural model of the arbiter.
module tb_uc_arbiter;
  localparam int N  = 4;
  localparam int LW = 9;
`ifdef UCA_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  uc_arbiter_if #(.NUM_ENG(N), .UC_LENGTH(512)) bus ();

  uc_arbiter #(.NUM_ENG(N), .UC_LENGTH(512)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a one-slot buffer, a priority pointer and the last accepted literal.
  bit           m_on = 1'b0;
  bit           m_hold_v;
  logic [LW-1:0] m_hold_lit;
  int           m_rr;
  bit           m_last_v;
  logic [LW-1:0] m_last_lit;
  int           e_g;
  bit           e_push, e_acc;
  logic [N-1:0] e_ready;

  always @(negedge clk) begin
    int idx;
    if (m_on) begin
      e_g = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (e_g < 0 && bus.eng2uca_valid[idx]) e_g = idx;
      end
      e_push  = m_hold_v && (bus.ucq_full == '0) && !flush && !rst;
      e_acc   = (e_g >= 0) && (!m_hold_v || e_push) && !flush && !rst;
      e_ready = e_acc ? N'(1 << e_g) : '0;
      check("model_ready", 32'(bus.uca2eng_ready), 32'(e_ready));
      check("model_push",  32'(bus.uca2ucq_push),  32'(e_push));
      check("model_lit",   32'(bus.uca2ucq),       32'(m_hold_lit));
    end
  end

  always @(posedge clk) begin
    logic [LW-1:0] lit;
    bit dup;
    if (rst) begin
      m_on = 1'b1; m_hold_v = 1'b0; m_hold_lit = '0; m_rr = 0; m_last_v = 1'b0; m_last_lit = '0;
    end else if (m_on) begin
      if (flush) begin
        m_hold_v = 1'b0;
        m_last_v = 1'b0;
      end else begin
        if (e_push) m_hold_v = 1'b0;
        if (e_acc) begin
          lit = bus.eng2uca_lit[e_g];
          dup = DEDUP && m_last_v && (lit == m_last_lit);
          if (!dup) begin
            m_hold_v   = 1'b1;
            m_hold_lit = lit;
          end
          m_last_v   = 1'b1;
          m_last_lit = lit;
          m_rr       = (e_g + 1) % N;
        end
      end
    end
  end

  // One cycle of stimulus, applied just after the edge; returns at the sampling edge.
  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] full, input logic fl,
                       input logic r, input logic [N-1:0][LW-1:0] l);
    @(posedge clk); #1;
    bus.eng2uca_valid = v;
    bus.eng2uca_lit   = l;
    bus.ucq_full      = full;
    flush             = fl;
    rst               = r;
    @(negedge clk);
  endtask

  logic [N-1:0][LW-1:0] L;

  task automatic do_reset();
    drive('0, '0, 1'b0, 1'b1, L);
    drive('0, '0, 1'b0, 1'b1, L);
    drive('0, '0, 1'b0, 1'b0, L);
  endtask

  initial begin
    logic [N-1:0] v;
    logic [N-1:0] full;
    logic [N-1:0] acc;
    bit fl, r;
    bus.eng2uca_valid = '0;
    bus.eng2uca_lit   = '0;
    bus.ucq_full      = '0;
    L = '0;

    // Reset state and single literal latency
    do_reset();
    check("reset_ready", 32'(bus.uca2eng_ready), 32'h0);
    check("reset_push",  32'(bus.uca2ucq_push),  32'h0);
    check("reset_lit",   32'(bus.uca2ucq),       32'h0);
    L[2] = 9'h05;
    drive(4'b0100, '0, 1'b0, 1'b0, L);
    check("t1_ready", 32'(bus.uca2eng_ready), 32'h4);
    check("t1_nopush", 32'(bus.uca2ucq_push), 32'h0);
    drive('0, '0, 1'b0, 1'b0, L);
    check("t1_push", 32'(bus.uca2ucq_push), 32'h1);
    check("t1_lit",  32'(bus.uca2ucq),      32'h05);
    drive('0, '0, 1'b0, 1'b0, L);
    check("t1_idle", 32'(bus.uca2ucq_push), 32'h0);
    $display("scenario single_offer done");

    // Round robin with all engines valid
    do_reset();
    for (int i = 0; i < N; i++) L[i] = LW'(9'h10 + i);
    for (int c = 0; c < 6; c++) begin
      drive(4'b1111, '0, 1'b0, 1'b0, L);
      check("t2_ready", 32'(bus.uca2eng_ready), 32'(1 << (c % 4)));
      if (c >= 1) begin
        check("t2_push", 32'(bus.uca2ucq_push), 32'h1);
        check("t2_lit",  32'(bus.uca2ucq),      32'(9'h10 + ((c - 1) % 4)));
      end
    end
    drive('0, '0, 1'b0, 1'b0, L);
    $display("scenario round_robin done");

    // Backpressure holds the stage and all ready bits
    do_reset();
    L[0] = 9'h21; L[1] = 9'h22;
    drive(4'b0001, '0, 1'b0, 1'b0, L);
    check("t3_ready0", 32'(bus.uca2eng_ready), 32'h1);
    for (int c = 0; c < 3; c++) begin
      drive(4'b0010, 4'b0100, 1'b0, 1'b0, L);
      check("t3_stall_push",  32'(bus.uca2ucq_push),  32'h0);
      check("t3_stall_ready", 32'(bus.uca2eng_ready), 32'h0);
    end
    drive(4'b0010, '0, 1'b0, 1'b0, L);
    check("t3_push",  32'(bus.uca2ucq_push),  32'h1);
    check("t3_lit",   32'(bus.uca2ucq),       32'h21);
    check("t3_ready", 32'(bus.uca2eng_ready), 32'h2);
    drive('0, '0, 1'b0, 1'b0, L);
    check("t3_lit2", 32'(bus.uca2ucq), 32'h22);
    drive('0, '0, 1'b0, 1'b0, L);
    $display("scenario backpressure done");

    // Flush while stalled discards the held literal
    do_reset();
    L[0] = 9'h33; L[1] = 9'h07;
    drive(4'b0001, '0, 1'b0, 1'b0, L);
    drive('0, 4'b1111, 1'b0, 1'b0, L);
    check("t4_stall", 32'(bus.uca2ucq_push), 32'h0);
    drive(4'b0010, 4'b1111, 1'b1, 1'b0, L);
    check("t4_flush_push",  32'(bus.uca2ucq_push),  32'h0);
    check("t4_flush_ready", 32'(bus.uca2eng_ready), 32'h0);
    drive(4'b0010, '0, 1'b0, 1'b0, L);
    check("t4_after_push",  32'(bus.uca2ucq_push),  32'h0);
    check("t4_after_ready", 32'(bus.uca2eng_ready), 32'h2);
    drive('0, '0, 1'b0, 1'b0, L);
    check("t4_push", 32'(bus.uca2ucq_push), 32'h1);
    check("t4_lit",  32'(bus.uca2ucq),      32'h07);
    drive('0, '0, 1'b0, 1'b0, L);
    $display("scenario flush done");

    // Back-to-back identical literals
    do_reset();
    L[0] = 9'h44; L[1] = 9'h44; L[2] = 9'h44;
    drive(4'b0011, '0, 1'b0, 1'b0, L);
    check("t5_ready0", 32'(bus.uca2eng_ready), 32'h1);
    drive(4'b0010, '0, 1'b0, 1'b0, L);
    check("t5_ready1", 32'(bus.uca2eng_ready), 32'h2);
    check("t5_push1",  32'(bus.uca2ucq_push),  32'h1);
    drive('0, '0, 1'b0, 1'b0, L);
    check("t5_push2", 32'(bus.uca2ucq_push), DEDUP ? 32'h0 : 32'h1);
    drive('0, '0, 1'b1, 1'b0, L);
    drive(4'b0100, '0, 1'b0, 1'b0, L);
    check("t5_ready2", 32'(bus.uca2eng_ready), 32'h4);
    drive('0, '0, 1'b0, 1'b0, L);
    check("t5_push3", 32'(bus.uca2ucq_push), 32'h1);
    check("t5_lit3",  32'(bus.uca2ucq),      32'h44);
    $display("scenario duplicate done");

    // Reset mid-stream returns priority to engine 0
    do_reset();
    L[0] = 9'h55; L[3] = 9'h77;
    drive(4'b0001, '0, 1'b0, 1'b0, L);
    drive(4'b1001, 4'b1111, 1'b0, 1'b1, L);
    check("t6_rst_push",  32'(bus.uca2ucq_push),  32'h0);
    check("t6_rst_ready", 32'(bus.uca2eng_ready), 32'h0);
    L[0] = 9'h66;
    drive(4'b1001, '0, 1'b0, 1'b0, L);
    check("t6_push",  32'(bus.uca2ucq_push),  32'h0);
    check("t6_ready", 32'(bus.uca2eng_ready), 32'h1);
    drive(4'b1000, '0, 1'b0, 1'b0, L);
    check("t6_lit_a", 32'(bus.uca2ucq), 32'h66);
    check("t6_ready3", 32'(bus.uca2eng_ready), 32'h8);
    drive('0, '0, 1'b0, 1'b0, L);
    check("t6_lit_b", 32'(bus.uca2ucq), 32'h77);
    $display("scenario reset_midstream done");

    // Randomized traffic; engines hold each offer until accepted
    v = '0;
    for (int c = 0; c < 4000; c++) begin
      acc = v & bus.uca2eng_ready;
      for (int i = 0; i < N; i++) begin
        if (acc[i] || !v[i]) begin
          v[i] = ($urandom % 3) != 0;
          L[i] = LW'($urandom % 8);
        end
      end
      full = (($urandom % 4) == 0) ? N'($urandom) : '0;
      fl   = ($urandom % 25) == 0;
      r    = ($urandom % 150) == 0;
      drive(v, full, fl, r, L);
      if (r) v = v;
    end
    drive('0, '0, 1'b0, 1'b0, L);
    $display("scenario random done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
